// File: rtl/usb_fifo_responder_if.sv
// -----------------------------------------------------------------------------
// usb_fifo_responder_if
// Groups the FT245-style sequencer bus and the host-side RX/TX streams of the
// USB FIFO responder.
//   Sequencer bus : rd_n, wr_n, data_in (toward responder)
//                   data_out, data_oe, rxf_n, txe_n (toward sequencer)
//   Host RX stream: host_rx_data/host_rx_valid in, host_rx_ready out
//   Host TX stream: host_tx_data/host_tx_valid out, host_tx_ready in
// Modports:
//   master - the sequencer/host environment that drives the responder
//   slave  - the responder itself
// -----------------------------------------------------------------------------
interface usb_fifo_responder_if;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       rxf_n;
    logic       txe_n;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_ready;
    logic [7:0] host_tx_data;
    logic       host_tx_valid;
    logic       host_tx_ready;

    modport master (
        output rd_n, wr_n, data_in, host_rx_data, host_rx_valid, host_tx_ready,
        input  data_out, data_oe, rxf_n, txe_n, host_rx_ready, host_tx_data, host_tx_valid
    );

    modport slave (
        input  rd_n, wr_n, data_in, host_rx_data, host_rx_valid, host_tx_ready,
        output data_out, data_oe, rxf_n, txe_n, host_rx_ready, host_tx_data, host_tx_valid
    );
endinterface

// File: rtl/usb_fifo_responder.sv
// -----------------------------------------------------------------------------
// usb_fifo_responder
// Device-side model of an FT245-style USB FIFO chip. Answers rd_n strobes with
// bytes from an RX FIFO (filled by the host stream) and captures bytes written
// under wr_n strobes into a TX FIFO (drained by the host stream).
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   bus           - sequencer bus + host streams (slave modport)
//   clear_flags   - synchronous clear of the sticky flags
//   rx_level      - RX FIFO occupancy
//   tx_level      - TX FIFO occupancy
//   rd_underflow  - sticky: read strobe started while RX empty
//   wr_overflow   - sticky: write strobe started while TX full
// -----------------------------------------------------------------------------
module usb_fifo_responder #(
    parameter int RX_DEPTH        = 16,
    parameter int TX_DEPTH        = 16,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    usb_fifo_responder_if.slave           bus,
    input  logic                          clear_flags,
    output logic [$clog2(RX_DEPTH+1)-1:0] rx_level,
    output logic [$clog2(TX_DEPTH+1)-1:0] tx_level,
    output logic                          rd_underflow,
    output logic                          wr_overflow
);

    localparam int RXW = $clog2(RX_DEPTH + 1);
    localparam int TXW = $clog2(TX_DEPTH + 1);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam int TXA = $clog2(TX_DEPTH);
    localparam int CW  = (RECOVERY_CYCLES < 1) ? 1 : $clog2(RECOVERY_CYCLES + 1);
    localparam logic [CW-1:0] REC_LOAD = CW'(RECOVERY_CYCLES);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACTIVE = 2'd1, R_RECOVER = 2'd2} rx_state_t;
    typedef enum logic [1:0] {T_IDLE = 2'd0, T_ACTIVE = 2'd1, T_RECOVER = 2'd2} tx_state_t;

    // RX FIFO storage and bookkeeping
    logic [7:0]     rx_mem_r [RX_DEPTH];
    logic [RXA-1:0] rx_wr_ptr_r, rx_rd_ptr_r;
    logic [RXW-1:0] rx_count_r;
    logic           rx_empty_s, rx_full_s, rx_push_s, rx_pop_s;

    // TX FIFO storage and bookkeeping
    logic [7:0]     tx_mem_r [TX_DEPTH];
    logic [TXA-1:0] tx_wr_ptr_r, tx_rd_ptr_r;
    logic [TXW-1:0] tx_count_r;
    logic           tx_empty_s, tx_full_s, tx_push_s, tx_pop_s;

    // RX FSM
    rx_state_t      rx_state_r, rx_state_s;
    logic [CW-1:0]  rx_cnt_r, rx_cnt_s;
    logic           rx_strobe_empty_r, rx_strobe_empty_s;
    logic           rx_uflow_set_s;

    // TX FSM
    tx_state_t      tx_state_r, tx_state_s;
    logic [CW-1:0]  tx_cnt_r, tx_cnt_s;
    logic           tx_oflow_set_s;

    logic           rd_underflow_r, wr_overflow_r;

    assign rx_empty_s = (rx_count_r == RXW'(0));
    assign rx_full_s  = (rx_count_r == RXW'(RX_DEPTH));
    assign tx_empty_s = (tx_count_r == TXW'(0));
    assign tx_full_s  = (tx_count_r == TXW'(TX_DEPTH));

    // Host push is gated by the registered count, so a pop at a full edge
    // cannot make room for a push at that same edge.
    assign rx_push_s = bus.host_rx_valid && !rx_full_s;
    assign tx_pop_s  = bus.host_tx_ready && !tx_empty_s;

    assign bus.host_rx_ready = !rx_full_s;
    assign bus.host_tx_valid = !tx_empty_s;
    assign bus.host_tx_data  = tx_empty_s ? 8'h00 : tx_mem_r[tx_rd_ptr_r];
    assign bus.data_oe       = !bus.rd_n;
    // Head only moves at the end of a strobe, so it is stable while rd_n is low.
    assign bus.data_out      = rx_empty_s ? 8'h00 : rx_mem_r[rx_rd_ptr_r];
    assign bus.rxf_n         = !(((rx_state_r == R_IDLE) && !rx_empty_s) ||
                                 ((rx_state_r == R_ACTIVE) && !rx_strobe_empty_r));
    assign bus.txe_n         = !((tx_state_r == T_IDLE) && !tx_full_s);

    assign rx_level     = rx_count_r;
    assign tx_level     = tx_count_r;
    assign rd_underflow = rd_underflow_r;
    assign wr_overflow  = wr_overflow_r;

    // RX FSM next-state: start strobe, pop at its end, then hold off for recovery.
    always_comb begin
        rx_state_s        = rx_state_r;
        rx_cnt_s          = rx_cnt_r;
        rx_strobe_empty_s = rx_strobe_empty_r;
        rx_pop_s          = 1'b0;
        rx_uflow_set_s    = 1'b0;
        case (rx_state_r)
            R_IDLE: begin
                if (!bus.rd_n) begin
                    rx_state_s        = R_ACTIVE;
                    rx_strobe_empty_s = rx_empty_s;
                    rx_uflow_set_s    = rx_empty_s;
                end else begin
                    rx_state_s = R_IDLE;
                end
            end
            R_ACTIVE: begin
                if (bus.rd_n) begin
                    // Only the sequencer pops RX, so a non-empty strobe still has its byte.
                    rx_pop_s   = !rx_strobe_empty_r;
                    rx_cnt_s   = REC_LOAD;
                    rx_state_s = (RECOVERY_CYCLES == 0) ? R_IDLE : R_RECOVER;
                end else begin
                    rx_state_s = R_ACTIVE;
                end
            end
            R_RECOVER: begin
                // Leaving when the count steps from 1 to 0 gives exactly
                // RECOVERY_CYCLES cycles in this state.
                if (rx_cnt_r <= CW'(1)) begin
                    rx_cnt_s   = CW'(0);
                    rx_state_s = R_IDLE;
                end else begin
                    rx_cnt_s   = rx_cnt_r - CW'(1);
                    rx_state_s = R_RECOVER;
                end
            end
            default: begin
                rx_state_s = R_IDLE;
                rx_cnt_s   = CW'(0);
            end
        endcase
    end

    // TX FSM next-state: exactly one capture at the strobe's first low edge.
    always_comb begin
        tx_state_s     = tx_state_r;
        tx_cnt_s       = tx_cnt_r;
        tx_push_s      = 1'b0;
        tx_oflow_set_s = 1'b0;
        case (tx_state_r)
            T_IDLE: begin
                if (!bus.wr_n) begin
                    tx_state_s     = T_ACTIVE;
                    tx_push_s      = !tx_full_s;
                    tx_oflow_set_s = tx_full_s;
                end else begin
                    tx_state_s = T_IDLE;
                end
            end
            T_ACTIVE: begin
                if (bus.wr_n) begin
                    tx_cnt_s   = REC_LOAD;
                    tx_state_s = (RECOVERY_CYCLES == 0) ? T_IDLE : T_RECOVER;
                end else begin
                    tx_state_s = T_ACTIVE;
                end
            end
            T_RECOVER: begin
                if (tx_cnt_r <= CW'(1)) begin
                    tx_cnt_s   = CW'(0);
                    tx_state_s = T_IDLE;
                end else begin
                    tx_cnt_s   = tx_cnt_r - CW'(1);
                    tx_state_s = T_RECOVER;
                end
            end
            default: begin
                tx_state_s = T_IDLE;
                tx_cnt_s   = CW'(0);
            end
        endcase
    end

    // FSM state, recovery counters and strobe-empty marker.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_r        <= R_IDLE;
            rx_cnt_r          <= CW'(0);
            rx_strobe_empty_r <= 1'b0;
            tx_state_r        <= T_IDLE;
            tx_cnt_r          <= CW'(0);
        end else begin
            rx_state_r        <= rx_state_s;
            rx_cnt_r          <= rx_cnt_s;
            rx_strobe_empty_r <= rx_strobe_empty_s;
            tx_state_r        <= tx_state_s;
            tx_cnt_r          <= tx_cnt_s;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_ptr_r <= RXA'(0);
            rx_rd_ptr_r <= RXA'(0);
            rx_count_r  <= RXW'(0);
            tx_wr_ptr_r <= TXA'(0);
            tx_rd_ptr_r <= TXA'(0);
            tx_count_r  <= TXW'(0);
        end else begin
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + RXA'(1);
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + RXA'(1);
            if (rx_push_s && !rx_pop_s)      rx_count_r <= rx_count_r + RXW'(1);
            else if (!rx_push_s && rx_pop_s) rx_count_r <= rx_count_r - RXW'(1);
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + TXA'(1);
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + TXA'(1);
            if (tx_push_s && !tx_pop_s)      tx_count_r <= tx_count_r + TXW'(1);
            else if (!tx_push_s && tx_pop_s) tx_count_r <= tx_count_r - TXW'(1);
        end
    end

    // FIFO data storage; contents need no reset since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= bus.host_rx_data;
        if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= bus.data_in;
    end

    // Sticky flags: a new violation at a clear edge takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_underflow_r <= 1'b0;
            wr_overflow_r  <= 1'b0;
        end else begin
            if (rx_uflow_set_s)   rd_underflow_r <= 1'b1;
            else if (clear_flags) rd_underflow_r <= 1'b0;
            if (tx_oflow_set_s)   wr_overflow_r  <= 1'b1;
            else if (clear_flags) wr_overflow_r  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_fifo_responder.sv
// -----------------------------------------------------------------------------
// tb_usb_fifo_responder
// Directed bench for usb_fifo_responder. Host pushes and sequencer writes put
// their expected bytes on scoreboard queues; sequencer reads and host drains
// pop and compare. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_usb_fifo_responder;
    logic       clk;
    logic       reset_n;
    logic       clear_flags;
    logic [4:0] rx_level;
    logic [4:0] tx_level;
    logic       rd_underflow;
    logic       wr_overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rxq [$];
    logic [7:0] txq [$];

    usb_fifo_responder_if bus();

    usb_fifo_responder #(
        .RX_DEPTH(16), .TX_DEPTH(16), .RECOVERY_CYCLES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .clear_flags(clear_flags),
        .rx_level(rx_level), .tx_level(tx_level),
        .rd_underflow(rd_underflow), .wr_overflow(wr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic host_push(input logic [7:0] b);
        int guard = 0;
        while (bus.host_rx_ready !== 1'b1 && guard < 50) begin
            cyc(1);
            guard++;
        end
        check("host_rx_ready_wait", 32'(bus.host_rx_ready), 32'd1);
        bus.host_rx_data  = b;
        bus.host_rx_valid = 1'b1;
        cyc(1);
        bus.host_rx_valid = 1'b0;
        rxq.push_back(b);
    endtask

    // rd_n low for 2 cycles, high afterwards; checks data and recovery.
    task automatic seq_read(input string tag);
        logic [7:0] exp;
        logic       was_empty;
        was_empty = (rxq.size() == 0);
        if (was_empty) exp = 8'h00;
        else           exp = rxq.pop_front();
        bus.rd_n = 1'b0;
        #1;
        check({tag, "_oe_on"}, 32'(bus.data_oe), 32'd1);
        cyc(1);
        check({tag, "_data"}, 32'(bus.data_out), 32'(exp));
        check({tag, "_rxf_active"}, 32'(bus.rxf_n), 32'(was_empty));
        cyc(1);
        bus.rd_n = 1'b1;
        #1;
        check({tag, "_oe_off"}, 32'(bus.data_oe), 32'd0);
        cyc(1);
        check({tag, "_rxf_rec1"}, 32'(bus.rxf_n), 32'd1);
        cyc(1);
        check({tag, "_rxf_rec2"}, 32'(bus.rxf_n), 32'd1);
        cyc(1);
        check({tag, "_rxf_idle"}, 32'(bus.rxf_n), 32'(rxq.size() == 0));
    endtask

    // Data set up one cycle ahead, wr_n low 2 cycles; bus changes after capture.
    task automatic seq_write(input string tag, input logic [7:0] b, input bit wait_txe);
        int guard = 0;
        if (wait_txe) begin
            while (bus.txe_n !== 1'b0 && guard < 50) begin
                cyc(1);
                guard++;
            end
            check({tag, "_txe_wait"}, 32'(bus.txe_n), 32'd0);
        end
        bus.data_in = b;
        cyc(1);
        bus.wr_n = 1'b0;
        if (txq.size() < 16) txq.push_back(b);
        cyc(1);
        bus.data_in = ~b;
        cyc(1);
        bus.wr_n    = 1'b1;
        bus.data_in = 8'h00;
        cyc(1);
        check({tag, "_txe_rec1"}, 32'(bus.txe_n), 32'd1);
        cyc(1);
        check({tag, "_txe_rec2"}, 32'(bus.txe_n), 32'd1);
        cyc(1);
        check({tag, "_txe_idle"}, 32'(bus.txe_n), 32'(txq.size() >= 16));
    endtask

    task automatic host_drain(input string tag);
        while (txq.size() > 0) begin
            check({tag, "_tx_valid"}, 32'(bus.host_tx_valid), 32'd1);
            check({tag, "_tx_data"}, 32'(bus.host_tx_data), 32'(txq.pop_front()));
            bus.host_tx_ready = 1'b1;
            cyc(1);
            bus.host_tx_ready = 1'b0;
        end
        check({tag, "_tx_empty"}, 32'(bus.host_tx_valid), 32'd0);
        check({tag, "_tx_level0"}, 32'(tx_level), 32'd0);
    endtask

    initial begin
        logic [7:0] exp;
        reset_n           = 1'b0;
        clear_flags       = 1'b0;
        bus.rd_n          = 1'b1;
        bus.wr_n          = 1'b1;
        bus.data_in       = 8'h00;
        bus.host_rx_data  = 8'h00;
        bus.host_rx_valid = 1'b0;
        bus.host_tx_ready = 1'b0;
        cyc(2);
        check("rst_rxf_n", 32'(bus.rxf_n), 32'd1);
        check("rst_txe_n", 32'(bus.txe_n), 32'd0);
        check("rst_rx_level", 32'(rx_level), 32'd0);
        check("rst_tx_level", 32'(tx_level), 32'd0);
        check("rst_host_rx_ready", 32'(bus.host_rx_ready), 32'd1);
        check("rst_host_tx_valid", 32'(bus.host_tx_valid), 32'd0);
        check("rst_data_oe", 32'(bus.data_oe), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_flags", 32'({rd_underflow, wr_overflow}), 32'd0);
        reset_n = 1'b1;
        cyc(1);

        // Two host bytes, two sequencer reads
        host_push(8'hA5);
        check("t1_rxf_after_push", 32'(bus.rxf_n), 32'd0);
        host_push(8'h3C);
        check("t1_rx_level2", 32'(rx_level), 32'd2);
        seq_read("t1_rd0");
        seq_read("t1_rd1");
        check("t1_rx_level0", 32'(rx_level), 32'd0);

        // Four sequencer writes, then host drain
        seq_write("t2_w0", 8'h15, 1'b1);
        seq_write("t2_w1", 8'h26, 1'b1);
        seq_write("t2_w2", 8'h37, 1'b1);
        seq_write("t2_w3", 8'h48, 1'b1);
        check("t2_tx_level4", 32'(tx_level), 32'd4);
        host_drain("t2");

        // TX fill to 16 plus one overflowing strobe
        for (int i = 0; i < 16; i++) seq_write("t3_w", 8'h40 + 8'(i), 1'b1);
        check("t3_tx_level16", 32'(tx_level), 32'd16);
        check("t3_txe_full", 32'(bus.txe_n), 32'd1);
        check("t3_ovf_before", 32'(wr_overflow), 32'd0);
        seq_write("t3_w16", 8'hFF, 1'b0);
        check("t3_ovf_set", 32'(wr_overflow), 32'd1);
        check("t3_tx_level_hold", 32'(tx_level), 32'd16);
        host_drain("t3");
        clear_flags = 1'b1;
        cyc(1);
        clear_flags = 1'b0;
        check("t3_ovf_cleared", 32'(wr_overflow), 32'd0);

        // Read strobe with RX empty
        seq_read("t4_empty");
        check("t4_underflow", 32'(rd_underflow), 32'd1);
        check("t4_rx_level0", 32'(rx_level), 32'd0);
        bus.host_rx_data  = 8'h5A;
        bus.host_rx_valid = 1'b1;
        cyc(1);
        bus.host_rx_valid = 1'b0;
        rxq.push_back(8'h5A);
        check("t4_rxf_next", 32'(bus.rxf_n), 32'd0);
        seq_read("t4_rd");

        // RX full, push held during a pop, order across pointer wrap
        for (int i = 0; i < 16; i++) host_push(8'h80 + 8'(i));
        check("t5_rx_level16", 32'(rx_level), 32'd16);
        check("t5_ready_full", 32'(bus.host_rx_ready), 32'd0);
        exp = rxq.pop_front();
        bus.host_rx_data  = 8'hEE;
        bus.host_rx_valid = 1'b1;
        bus.rd_n          = 1'b0;
        cyc(1);
        check("t5_head", 32'(bus.data_out), 32'(exp));
        cyc(1);
        bus.rd_n = 1'b1;
        cyc(1);
        check("t5_no_push_at_pop", 32'(rx_level), 32'd15);
        check("t5_ready_after_pop", 32'(bus.host_rx_ready), 32'd1);
        cyc(1);
        bus.host_rx_valid = 1'b0;
        rxq.push_back(8'hEE);
        check("t5_refill16", 32'(rx_level), 32'd16);
        cyc(1);
        for (int i = 0; i < 16; i++) seq_read("t5_rd");
        check("t5_rx_level0", 32'(rx_level), 32'd0);

        // Reset in the middle of a read strobe with 3 bytes queued
        host_push(8'h11);
        host_push(8'h22);
        host_push(8'h33);
        check("t6_uflow_pre", 32'(rd_underflow), 32'd1);
        bus.rd_n = 1'b0;
        cyc(1);
        #2;
        reset_n = 1'b0;
        #1;
        rxq.delete();
        check("t6_rxf_n", 32'(bus.rxf_n), 32'd1);
        check("t6_rx_level", 32'(rx_level), 32'd0);
        check("t6_txe_n", 32'(bus.txe_n), 32'd0);
        check("t6_flags", 32'({rd_underflow, wr_overflow}), 32'd0);
        check("t6_host_rx_ready", 32'(bus.host_rx_ready), 32'd1);
        check("t6_data_out", 32'(bus.data_out), 32'd0);
        check("t6_data_oe", 32'(bus.data_oe), 32'd1);
        @(negedge clk);
        bus.rd_n = 1'b1;
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        seq_read("t6_rd");
        check("t6_uflow_after", 32'(rd_underflow), 32'd1);
        check("t6_rx_level_after", 32'(rx_level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
